// File: rtl/bank_access_arbiter.sv
// Two-port arbiter onto four single-ported banks.
// Conflicts resolved by a 1-bit round-robin pointer; reads return two cycles after grant.
module bank_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_a_req,
    input  logic                      i_a_we,
    input  logic [ADDR_WIDTH-1:0]     i_a_addr,
    input  logic [DATA_WIDTH-1:0]     i_a_wdata,
    input  logic                      i_b_req,
    input  logic                      i_b_we,
    input  logic [ADDR_WIDTH-1:0]     i_b_addr,
    input  logic [DATA_WIDTH-1:0]     i_b_wdata,
    output logic                      o_a_gnt,
    output logic                      o_b_gnt,
    output logic                      o_a_rvalid,
    output logic                      o_b_rvalid,
    output logic [DATA_WIDTH-1:0]     o_a_rdata,
    output logic [DATA_WIDTH-1:0]     o_b_rdata,
    output logic [3:0]                o_bank_en,
    output logic [3:0]                o_bank_we,
    output logic [4*(ADDR_WIDTH-2)-1:0] o_bank_addr,
    output logic [4*DATA_WIDTH-1:0]   o_bank_wdata,
    input  logic [4*DATA_WIDTH-1:0]   i_bank_rdata
);

    localparam int RW = ADDR_WIDTH - 2;

    logic [1:0] a_bank, b_bank;
    logic       conflict;
    logic       a_gnt, b_gnt;
    logic       rr_q, rr_d;

    logic [3:0]               en_q, en_d;
    logic [3:0]               we_q, we_d;
    logic [4*RW-1:0]          addr_q, addr_d;
    logic [4*DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic       a_rd1_q, b_rd1_q;
    logic [1:0] a_bk1_q, b_bk1_q;
    logic       a_rv_q, b_rv_q;
    logic [1:0] a_bk2_q, b_bk2_q;
    logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q;
    logic [DATA_WIDTH-1:0] bank_rd [4];

    assign a_bank = i_a_addr[ADDR_WIDTH-1 -: 2];
    assign b_bank = i_b_addr[ADDR_WIDTH-1 -: 2];

    always_comb begin
        conflict = i_a_req & i_b_req & (a_bank == b_bank);
        a_gnt    = i_rst_n & i_a_req & (~conflict | ~rr_q);
        b_gnt    = i_rst_n & i_b_req & (~conflict | rr_q);
        // pointer moves to the loser so it wins the next clash
        rr_d     = conflict ? ~rr_q : rr_q;
    end

    assign o_a_gnt = a_gnt;
    assign o_b_gnt = b_gnt;

    always_comb begin
        en_d    = '0;
        we_d    = '0;
        addr_d  = '0;
        wdata_d = '0;
        for (int k = 0; k < 4; k++) begin
            if (a_gnt && a_bank == 2'(k)) begin
                en_d[k]                          = 1'b1;
                we_d[k]                          = i_a_we;
                addr_d[k*RW +: RW]               = i_a_addr[RW-1:0];
                wdata_d[k*DATA_WIDTH +: DATA_WIDTH] = i_a_wdata;
            end else if (b_gnt && b_bank == 2'(k)) begin
                en_d[k]                          = 1'b1;
                we_d[k]                          = i_b_we;
                addr_d[k*RW +: RW]               = i_b_addr[RW-1:0];
                wdata_d[k*DATA_WIDTH +: DATA_WIDTH] = i_b_wdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q    <= 1'b0;
            en_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_bank_en    = en_q;
    assign o_bank_we    = we_q;
    assign o_bank_addr  = addr_q;
    assign o_bank_wdata = wdata_q;

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign bank_rd[g] = i_bank_rdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // stage 1 tracks the strobe cycle, stage 2 the cycle the bank data is live
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_rd1_q  <= 1'b0;
            b_rd1_q  <= 1'b0;
            a_bk1_q  <= '0;
            b_bk1_q  <= '0;
            a_rv_q   <= 1'b0;
            b_rv_q   <= 1'b0;
            a_bk2_q  <= '0;
            b_bk2_q  <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            a_rd1_q <= a_gnt & ~i_a_we;
            b_rd1_q <= b_gnt & ~i_b_we;
            a_bk1_q <= a_bank;
            b_bk1_q <= b_bank;
            a_rv_q  <= a_rd1_q;
            b_rv_q  <= b_rd1_q;
            a_bk2_q <= a_bk1_q;
            b_bk2_q <= b_bk1_q;
            if (a_rv_q) a_hold_q <= bank_rd[a_bk2_q];
            if (b_rv_q) b_hold_q <= bank_rd[b_bk2_q];
        end
    end

    assign o_a_rvalid = a_rv_q;
    assign o_b_rvalid = b_rv_q;
    assign o_a_rdata  = a_rv_q ? bank_rd[a_bk2_q] : a_hold_q;
    assign o_b_rdata  = b_rv_q ? bank_rd[b_bk2_q] : b_hold_q;

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Directed bench for bank_access_arbiter with a synchronous-read ROM bank model.
module tb_bank_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [5:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0]  a_rdata, b_rdata;
    logic [3:0]  bank_en, bank_we;
    logic [15:0] bank_addr;
    logic [31:0] bank_wdata;
    logic [31:0] bank_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bank_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_a_gnt(a_gnt), .o_b_gnt(b_gnt),
        .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
        .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
        .o_bank_en(bank_en), .o_bank_we(bank_we),
        .o_bank_addr(bank_addr), .o_bank_wdata(bank_wdata),
        .i_bank_rdata(bank_rdata)
    );

    function automatic logic [7:0] rom(input logic [5:0] a);
        case (a)
            6'h03:   rom = 8'h11;
            6'h31:   rom = 8'h33;
            6'h01:   rom = 8'hC0;
            6'h12:   rom = 8'hC1;
            6'h23:   rom = 8'hC2;
            6'h34:   rom = 8'hC3;
            default: rom = 8'hEE;
        endcase
    endfunction

    // bank data appears the cycle after the strobe
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (bank_en[k] && !bank_we[k])
                bank_rdata[k*8 +: 8] <= rom({2'(k), bank_addr[k*4 +: 4]});
    end

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        @(negedge clk);
        a_req = 1; b_req = 1;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt got=%b want=00", {a_gnt, b_gnt});
        end
        total++;
        if ({bank_en, bank_we, bank_addr, bank_wdata} !== '0) begin
            bad++; $display("FAIL reset_bank got en=%b we=%b addr=%h wd=%h want 0",
                            bank_en, bank_we, bank_addr, bank_wdata);
        end
        total++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
            bad++; $display("FAIL reset_rd got rv=%b%b a=%h b=%h want 0",
                            a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
    endtask

    task automatic test_write();
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 6'h25; a_wdata = 8'hA5;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL write_gnt got=%b want=10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bank_en !== 4'b0100 || bank_we !== 4'b0100) begin
            bad++; $display("FAIL write_en got en=%b we=%b want 0100/0100", bank_en, bank_we);
        end
        total++;
        if (bank_addr !== 16'h0500 || bank_wdata !== 32'h00A5_0000) begin
            bad++; $display("FAIL write_slice got addr=%h wd=%h want 0500/00a50000",
                            bank_addr, bank_wdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (bank_en !== 4'b0000 || a_rvalid !== 1'b0) begin
            bad++; $display("FAIL write_after got en=%b rv=%b want 0000/0", bank_en, a_rvalid);
        end
    endtask

    task automatic test_dual_read();
        @(negedge clk);
        a_req = 1; a_addr = 6'h03;
        b_req = 1; b_addr = 6'h31;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b11) begin
            bad++; $display("FAIL dual_gnt got=%b want=11", {a_gnt, b_gnt});
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bank_en !== 4'b1001 || bank_we !== 4'b0000 || bank_addr !== 16'h1003) begin
            bad++; $display("FAIL dual_strobe got en=%b we=%b addr=%h want 1001/0000/1003",
                            bank_en, bank_we, bank_addr);
        end
        @(negedge clk);
        #1;
        total++;
        if ({a_rvalid, b_rvalid} !== 2'b11 || a_rdata !== 8'h11 || b_rdata !== 8'h33) begin
            bad++; $display("FAIL dual_rdata got rv=%b%b a=%h b=%h want 11 11/33",
                            a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        @(negedge clk);
        #1;
        total++;
        if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 8'h11 || b_rdata !== 8'h33) begin
            bad++; $display("FAIL dual_hold got rv=%b%b a=%h b=%h want 00 11/33",
                            a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req = 1; a_we = 1; a_addr = 6'h12; a_wdata = 8'hAA;
            b_req = 1; b_we = 1; b_addr = 6'h17; b_wdata = 8'hBB;
            #1;
            total++;
            if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_gnt%0d got=%b", i, {a_gnt, b_gnt});
            end
            if (i > 0) begin
                total++;
                if (bank_en !== 4'b0010 ||
                    bank_addr !== ((i % 2 == 1) ? 16'h0020 : 16'h0070) ||
                    bank_wdata !== ((i % 2 == 1) ? 32'h0000_AA00 : 32'h0000_BB00)) begin
                    bad++; $display("FAIL rr_strobe%0d got en=%b addr=%h wd=%h",
                                    i, bank_en, bank_addr, bank_wdata);
                end
            end
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bank_en !== 4'b0010 || bank_addr !== 16'h0070 || bank_wdata !== 32'h0000_BB00) begin
            bad++; $display("FAIL rr_strobe3 got en=%b addr=%h wd=%h want 0010/0070/0000bb00",
                            bank_en, bank_addr, bank_wdata);
        end
        // clash (A wins, rr->B), lone A, then clash again must go to B
        @(negedge clk);
        a_req = 1; a_addr = 6'h20; b_req = 1; b_addr = 6'h2F;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL lone_pre got=%b want=10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        b_req = 0;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL lone_a got=%b want=10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        b_req = 1;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            bad++; $display("FAIL rr_hold got=%b want=01", {a_gnt, b_gnt});
        end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ad;
        logic       rv_exp;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) begin
                ad = {i[1:0], 4'(i + 1)};
                a_req = 1; a_we = 0; a_addr = ad;
            end else begin
                idle();
            end
            #1;
            if (i < 4) begin
                total++;
                if (a_gnt !== 1'b1) begin
                    bad++; $display("FAIL b2b_gnt%0d got=%b want=1", i, a_gnt);
                end
            end
            rv_exp = (i >= 2 && i <= 5);
            total++;
            if (a_rvalid !== rv_exp || b_rvalid !== 1'b0) begin
                bad++; $display("FAIL b2b_rv%0d got a=%b b=%b want a=%b b=0",
                                i, a_rvalid, b_rvalid, rv_exp);
            end
            if (rv_exp) begin
                total++;
                if (a_rdata !== 8'hC0 + 8'(i - 2)) begin
                    bad++; $display("FAIL b2b_data%0d got=%h want=%h",
                                    i, a_rdata, 8'hC0 + 8'(i - 2));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        a_req = 1; a_addr = 6'h03; b_req = 1; b_addr = 6'h05;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL rstf_gnt got=%b want=10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b00 || bank_en !== 4'b0000 || bank_addr !== 16'h0000) begin
            bad++; $display("FAIL rstf_clear got gnt=%b en=%b addr=%h want 00/0000/0000",
                            {a_gnt, b_gnt}, bank_en, bank_addr);
        end
        total++;
        if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            bad++; $display("FAIL rstf_rd got rv=%b%b a=%h b=%h want 00 00/00",
                            a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({a_rvalid, b_rvalid} !== 2'b00) begin
                bad++; $display("FAIL rstf_norv%0d got=%b%b want=00", i, a_rvalid, b_rvalid);
            end
        end
        @(negedge clk);
        a_req = 1; a_addr = 6'h03; b_req = 1; b_addr = 6'h05;
        #1;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL rstf_rr got=%b want=10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_dual_read();
        test_conflict();
        test_back_to_back();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
